egg_timer_core: RTL and testbench

EGG_TIMER_CORE -- requirements
Module: egg_timer_core

---
 rtl/egg_timer_core.sv | 174 +++++++++++++++++
 tb/tb_egg_timer_core.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/egg_timer_core.sv
// Egg-timer countdown core: loads mm:00 from SW, counts down in BCD once per CLK_HZ cycles.
// Optional macro TIMER_ALARM_BLINK_EN makes the DONE alarm blink at 2 Hz instead of staying lit.
module egg_timer_core #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       FPGA_RESET_N,
    input  logic       start_pulse,
    input  logic       clear_pulse,
    input  logic [9:0] SW,
    output logic [3:0] onesSecDisp,
    output logic [3:0] tensSecDisp,
    output logic [3:0] onesMinDisp,
    output logic [3:0] tensMinDisp,
    output logic [3:0] state,
    output logic       alarm
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] TICK_AT = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        st;
    logic [PW-1:0] presc;
    logic          tick;

`ifdef TIMER_ALARM_BLINK_EN
    localparam logic [PW-1:0] BLINK_AT = PW'(CLK_HZ / 4 - 1);
    logic [PW-1:0] blink_cnt;
`endif

    assign state = {2'b00, st};
    assign tick  = (presc == TICK_AT);

    // Preset minutes clamped to 99 and split into BCD without a divider.
    logic [6:0] sw_min;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic       load_nz;
    logic       unused_sw;

    assign sw_min    = (SW[6:0] > 7'd99) ? 7'd99 : SW[6:0];
    assign load_nz   = (sw_min != 7'd0);
    assign unused_sw = ^SW[9:7];

    always_comb begin
        load_tens = 4'd0;
        for (int t = 1; t < 10; t++) begin
            if (sw_min >= 7'(t * 10)) load_tens = 4'(t);
        end
        load_ones = 4'(sw_min - 7'(load_tens) * 7'd10);
    end

    // One-second BCD decrement with borrow chaining mm:ss.
    logic [3:0] dec_os, dec_ts, dec_om, dec_tm;
    logic       at_last;

    always_comb begin
        dec_os = onesSecDisp;
        dec_ts = tensSecDisp;
        dec_om = onesMinDisp;
        dec_tm = tensMinDisp;
        if (onesSecDisp != 4'd0) begin
            dec_os = onesSecDisp - 4'd1;
        end else begin
            dec_os = 4'd9;
            if (tensSecDisp != 4'd0) begin
                dec_ts = tensSecDisp - 4'd1;
            end else begin
                dec_ts = 4'd5;
                if (onesMinDisp != 4'd0) begin
                    dec_om = onesMinDisp - 4'd1;
                end else begin
                    dec_om = 4'd9;
                    dec_tm = tensMinDisp - 4'd1;
                end
            end
        end
    end

    // 00:01 (or a stray 00:00) ends the countdown instead of wrapping.
    assign at_last = (tensMinDisp == 4'd0) && (onesMinDisp == 4'd0) &&
                     (tensSecDisp == 4'd0) && (onesSecDisp <= 4'd1);

    always_ff @(posedge CLOCK_50 or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            st          <= S_IDLE;
            presc       <= '0;
            onesSecDisp <= 4'd0;
            tensSecDisp <= 4'd0;
            onesMinDisp <= 4'd0;
            tensMinDisp <= 4'd0;
            alarm       <= 1'b0;
`ifdef TIMER_ALARM_BLINK_EN
            blink_cnt   <= '0;
`endif
        end else begin
            case (st)
                S_IDLE: begin
                    presc       <= '0;
                    alarm       <= 1'b0;
                    onesSecDisp <= 4'd0;
                    tensSecDisp <= 4'd0;
                    onesMinDisp <= load_ones;
                    tensMinDisp <= load_tens;
                    if (!clear_pulse && start_pulse && load_nz) st <= S_RUN;
                end
                S_RUN: begin
                    if (clear_pulse) begin
                        st    <= S_IDLE;
                        presc <= '0;
                    end else if (start_pulse) begin
                        st    <= S_PAUSE;
                        presc <= '0;
                    end else if (tick) begin
                        presc <= '0;
                        if (at_last) begin
                            st          <= S_DONE;
                            alarm       <= 1'b1;
                            onesSecDisp <= 4'd0;
                            tensSecDisp <= 4'd0;
                            onesMinDisp <= 4'd0;
                            tensMinDisp <= 4'd0;
`ifdef TIMER_ALARM_BLINK_EN
                            blink_cnt   <= '0;
`endif
                        end else begin
                            onesSecDisp <= dec_os;
                            tensSecDisp <= dec_ts;
                            onesMinDisp <= dec_om;
                            tensMinDisp <= dec_tm;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    presc <= '0;
                    if (clear_pulse)      st <= S_IDLE;
                    else if (start_pulse) st <= S_RUN;
                end
                S_DONE: begin
                    presc <= '0;
                    if (clear_pulse || start_pulse) begin
                        st    <= S_IDLE;
                        alarm <= 1'b0;
`ifdef TIMER_ALARM_BLINK_EN
                        blink_cnt <= '0;
`endif
                    end else begin
`ifdef TIMER_ALARM_BLINK_EN
                        if (blink_cnt == BLINK_AT) begin
                            blink_cnt <= '0;
                            alarm     <= ~alarm;
                        end else begin
                            blink_cnt <= blink_cnt + PW'(1);
                        end
`else
                        alarm <= 1'b1;
`endif
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_egg_timer_core.sv
// Directed bench for egg_timer_core at CLK_HZ=8: vector table for IDLE/RUN basics,
// hand sequences for full countdown, pause/resume, alarm and asynchronous reset.
module tb_egg_timer_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_pulse = 1'b0;
    logic       clear_pulse = 1'b0;
    logic [9:0] sw = 10'd0;
    logic [3:0] ones_sec, tens_sec, ones_min, tens_min, state;
    logic       alarm;

    egg_timer_core #(.CLK_HZ(8)) dut (
        .CLOCK_50    (clk),
        .FPGA_RESET_N(rst_n),
        .start_pulse (start_pulse),
        .clear_pulse (clear_pulse),
        .SW          (sw),
        .onesSecDisp (ones_sec),
        .tensSecDisp (tens_sec),
        .onesMinDisp (ones_min),
        .tensMinDisp (tens_min),
        .state       (state),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [20:0] obs;
    assign obs = {state, tens_min, ones_min, tens_sec, ones_sec, alarm};

    typedef struct {
        logic       start;
        logic       clear;
        logic [9:0] swv;
        logic [20:0] want;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [20:0] ev(input logic [3:0] s, input logic [3:0] tm, input logic [3:0] om,
                                        input logic [3:0] ts, input logic [3:0] os, input logic al);
        return {s, tm, om, ts, os, al};
    endfunction

    function automatic vec_t mk(input logic s, input logic c, input logic [9:0] v, input logic [20:0] w);
        vec_t r;
        r.start = s;
        r.clear = c;
        r.swv   = v;
        r.want  = w;
        return r;
    endfunction

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic step(input logic s, input logic c, input logic [9:0] v);
        @(negedge clk);
        start_pulse = s;
        clear_pulse = c;
        sw          = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] blink_exp;

        vecs[0]  = mk(0, 0, 10'd0,   ev(0, 0, 0, 0, 0, 0));
        vecs[1]  = mk(0, 0, 10'd120, ev(0, 9, 9, 0, 0, 0));
        vecs[2]  = mk(0, 0, 10'd99,  ev(0, 9, 9, 0, 0, 0));
        vecs[3]  = mk(0, 0, 10'd45,  ev(0, 4, 5, 0, 0, 0));
        vecs[4]  = mk(1, 0, 10'd0,   ev(0, 0, 0, 0, 0, 0));
        vecs[5]  = mk(0, 0, 10'd906, ev(0, 1, 0, 0, 0, 0));
        vecs[6]  = mk(1, 0, 10'd10,  ev(1, 1, 0, 0, 0, 0));
        vecs[7]  = mk(0, 0, 10'd3,   ev(1, 1, 0, 0, 0, 0));
        for (int i = 8; i < 14; i++) vecs[i] = mk(0, 0, 10'd10, ev(1, 1, 0, 0, 0, 0));
        vecs[14] = mk(0, 0, 10'd10,  ev(1, 0, 9, 5, 9, 0));
        vecs[15] = mk(1, 1, 10'd10,  ev(0, 0, 9, 5, 9, 0));
        vecs[16] = mk(0, 0, 10'd10,  ev(0, 1, 0, 0, 0, 0));
        vecs[17] = mk(0, 1, 10'd7,   ev(0, 0, 7, 0, 0, 0));

        // Reset held across edges: everything zero.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs, ev(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].start, vecs[i].clear, vecs[i].swv);
            check($sformatf("vec%0d", i), obs, vecs[i].want);
        end

        // Full two-minute countdown to DONE.
        step(0, 0, 10'd2);
        check("cd_load", obs, ev(0, 0, 2, 0, 0, 0));
        step(1, 0, 10'd2);
        check("cd_start", obs, ev(1, 0, 2, 0, 0, 0));
        for (int e = 1; e <= 960; e++) begin
            step(0, 0, 10'd2);
            if (e == 7)   check("cd_pre_tick1", obs, ev(1, 0, 2, 0, 0, 0));
            if (e == 8)   check("cd_tick1", obs, ev(1, 0, 1, 5, 9, 0));
            if (e == 952) check("cd_0001", obs, ev(1, 0, 0, 0, 1, 0));
            if (e == 959) check("cd_0001_hold", obs, ev(1, 0, 0, 0, 1, 0));
            if (e == 960) check("cd_done", obs, ev(3, 0, 0, 0, 0, 1));
        end
`ifdef TIMER_ALARM_BLINK_EN
        blink_exp = 6'b110011;
`else
        blink_exp = 6'b111111;
`endif
        for (int k = 1; k < 6; k++) begin
            step(0, 0, 10'd2);
            check($sformatf("done_alarm%0d", k), obs, ev(3, 0, 0, 0, 0, blink_exp[5-k]));
        end
        step(1, 0, 10'd2);
        check("done_start_idle", obs, ev(0, 0, 0, 0, 0, 0));
        step(0, 0, 10'd2);
        check("done_reload", obs, ev(0, 0, 2, 0, 0, 0));

        // Pause after 5 cycles, hold 50 cycles with SW changed, resume.
        step(0, 0, 10'd1);
        step(1, 0, 10'd1);
        check("pz_run", obs, ev(1, 0, 1, 0, 0, 0));
        repeat (5) step(0, 0, 10'd1);
        step(1, 0, 10'd1);
        check("pz_pause", obs, ev(2, 0, 1, 0, 0, 0));
        for (int k = 0; k < 50; k++) begin
            step(0, 0, 10'd5);
            check($sformatf("pz_hold%0d", k), obs, ev(2, 0, 1, 0, 0, 0));
        end
        step(1, 0, 10'd5);
        check("pz_resume", obs, ev(1, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 10'd5);
            if (k < 8) check($sformatf("pz_wait%0d", k), obs, ev(1, 0, 1, 0, 0, 0));
            else       check("pz_tick", obs, ev(1, 0, 0, 5, 9, 0));
        end
        step(0, 1, 10'd5);
        check("pz_clear", obs, ev(0, 0, 0, 5, 9, 0));
        step(0, 0, 10'd5);
        check("pz_reload", obs, ev(0, 0, 5, 0, 0, 0));

        // Asynchronous reset between edges in the middle of RUN.
        step(0, 0, 10'd3);
        step(1, 0, 10'd3);
        repeat (3) step(0, 0, 10'd3);
        check("rs_running", obs, ev(1, 0, 3, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        check("rs_async", obs, ev(0, 0, 0, 0, 0, 0));
        step(0, 0, 10'd3);
        check("rs_held", obs, ev(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rs_first_load", obs, ev(0, 0, 3, 0, 0, 0));
        step(1, 0, 10'd3);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 10'd3);
            if (k < 8) check($sformatf("rs_wait%0d", k), obs, ev(1, 0, 3, 0, 0, 0));
            else       check("rs_tick", obs, ev(1, 0, 2, 5, 9, 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
